// File: rtl/mmcm_lock_supervisor.sv
// mmcm_lock_supervisor
// Sits between an MMCM/PLL and the logic it clocks. It pulses the MMCM
// reset, synchronises and qualifies LOCKED, retries a bounded number of
// times on lock timeout, then releases the downstream channel resets one
// by one. Any loss of lock re-runs the whole sequence.
// Optional feature macro: MMCM_SUP_LOSS_CNT_EN adds the loss_cnt port and
// its 16-bit saturating lock-loss counter.
module mmcm_lock_supervisor #(
   parameter int NUM_CH        = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int RST_CYCLES    = 8,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int RELEASE_GAP   = 16,
   parameter int MAX_RETRIES   = 4
) (
   input  logic                                clk_in,
   input  logic                                reset,
   input  logic                                mmcm_locked,
   input  logic                                force_relock,
   output logic                                mmcm_rst,
   output logic [NUM_CH-1:0]                   ch_reset,
   output logic                                locked,
   output logic                                fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]    retry_cnt
`ifdef MMCM_SUP_LOSS_CNT_EN
   ,
   output logic [15:0]                         loss_cnt
`endif
);

   localparam int RW     = $clog2(MAX_RETRIES + 1);
   localparam int TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int TMAX_B = (STABLE_CYCLES > RELEASE_GAP) ? STABLE_CYCLES : RELEASE_GAP;
   localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST    = TW'(RELEASE_GAP - 1);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

   localparam logic [2:0] ST_RST_PULSE = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_STABLE    = 3'd2;
   localparam logic [2:0] ST_RELEASE   = 3'd3;
   localparam logic [2:0] ST_RUN       = 3'd4;
   localparam logic [2:0] ST_FAULT     = 3'd5;

   logic [SYNC_STAGES-1:0] r_sync;
   logic [2:0]             r_state;
   logic [TW-1:0]          r_timer;
   logic                   r_mmcmRst;
   logic [NUM_CH-1:0]      r_chReset;
   logic                   r_locked;
   logic                   r_fault;
   logic [RW-1:0]          r_retry;
`ifdef MMCM_SUP_LOSS_CNT_EN
   logic [15:0]            r_lossCnt;
`endif

   logic                   w_lockS;
   logic [RW-1:0]          w_retryNext;
   logic [NUM_CH-1:0]      w_chShift;
   logic                   w_lastRelease;

   // Channels are released lowest index first by shifting zeros in from
   // bit 0; the release that empties the vector is the final one.
   assign w_lockS       = r_sync[SYNC_STAGES-1];
   assign w_retryNext   = r_retry + 1'b1;
   assign w_chShift     = r_chReset << 1;
   assign w_lastRelease = (w_chShift == '0);

   // Bring the asynchronous LOCKED into the clk_in domain.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], mmcm_locked};
      end
   end

   // Supervisor sequence: pulse, wait for lock, qualify, release, run.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state   <= ST_RST_PULSE;
         r_timer   <= '0;
         r_mmcmRst <= 1'b1;
         r_chReset <= '1;
         r_locked  <= 1'b0;
         r_fault   <= 1'b0;
         r_retry   <= '0;
`ifdef MMCM_SUP_LOSS_CNT_EN
         r_lossCnt <= '0;
`endif
      end else if (force_relock && (r_state != ST_RST_PULSE)) begin
         r_state   <= ST_RST_PULSE;
         r_timer   <= '0;
         r_mmcmRst <= 1'b1;
         r_chReset <= '1;
         r_locked  <= 1'b0;
         r_fault   <= 1'b0;
         r_retry   <= '0;
      end else begin
         case (r_state)
            ST_RST_PULSE: begin
               r_mmcmRst <= 1'b1;
               if (r_timer == RST_LAST) begin
                  r_state   <= ST_WAIT_LOCK;
                  r_timer   <= '0;
                  r_mmcmRst <= 1'b0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (w_lockS) begin
                  r_state <= ST_STABLE;
                  r_timer <= '0;
               end else if (r_timer == TMO_LAST) begin
                  r_retry   <= w_retryNext;
                  r_timer   <= '0;
                  r_mmcmRst <= 1'b1;
                  if (w_retryNext == RETRY_MAX) begin
                     r_state <= ST_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state <= ST_RST_PULSE;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_STABLE: begin
               if (!w_lockS) begin
                  r_state <= ST_WAIT_LOCK;
                  r_timer <= '0;
               end else if (r_timer == STABLE_LAST) begin
                  r_chReset <= w_chShift;
                  r_timer   <= '0;
                  if (w_lastRelease) begin
                     r_state  <= ST_RUN;
                     r_locked <= 1'b1;
                     r_retry  <= '0;
                  end else begin
                     r_state <= ST_RELEASE;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (!w_lockS) begin
                  r_state   <= ST_RST_PULSE;
                  r_timer   <= '0;
                  r_mmcmRst <= 1'b1;
                  r_chReset <= '1;
               end else if (r_timer == GAP_LAST) begin
                  r_chReset <= w_chShift;
                  r_timer   <= '0;
                  if (w_lastRelease) begin
                     r_state  <= ST_RUN;
                     r_locked <= 1'b1;
                     r_retry  <= '0;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_RUN: begin
               if (!w_lockS) begin
                  r_state   <= ST_RST_PULSE;
                  r_timer   <= '0;
                  r_mmcmRst <= 1'b1;
                  r_chReset <= '1;
                  r_locked  <= 1'b0;
`ifdef MMCM_SUP_LOSS_CNT_EN
                  if (r_lossCnt != 16'hFFFF) begin
                     r_lossCnt <= r_lossCnt + 16'd1;
                  end
`endif
               end
            end
            ST_FAULT: begin
               r_mmcmRst <= 1'b1;
               r_chReset <= '1;
               r_fault   <= 1'b1;
            end
            default: begin
               r_state   <= ST_RST_PULSE;
               r_timer   <= '0;
               r_mmcmRst <= 1'b1;
               r_chReset <= '1;
               r_locked  <= 1'b0;
               r_fault   <= 1'b0;
            end
         endcase
      end
   end

   assign mmcm_rst  = r_mmcmRst;
   assign ch_reset  = r_chReset;
   assign locked    = r_locked;
   assign fault     = r_fault;
   assign retry_cnt = r_retry;
`ifdef MMCM_SUP_LOSS_CNT_EN
   assign loss_cnt  = r_lossCnt;
`endif

endmodule
